// File: rtl/approx_mult_pipe_if.sv
// Operand/result stream bundle for approx_mult_pipe.
// The slave side is the multiplier and the master side is whatever feeds and drains it.
interface approx_mult_pipe_if #(
    parameter int W = 8
);
    logic           in_valid;
    logic           in_ready;
    logic [W-1:0]   in_x;
    logic [W-1:0]   in_y;
    logic           in_exact;
    logic           out_valid;
    logic           out_ready;
    logic [2*W-1:0] out_z;
    logic [2*W-1:0] out_err;

    modport master (
        output in_valid, in_x, in_y, in_exact, out_ready,
        input  in_ready, out_valid, out_z, out_err
    );

    modport slave (
        input  in_valid, in_x, in_y, in_exact, out_ready,
        output in_ready, out_valid, out_z, out_err
    );
endinterface

// File: rtl/approx_mult_pipe.sv
// Three-stage unsigned W x W multiplier with an optional approximate mode.
// In that mode the low L rows are OR-compressed in pairs and truncated below column T.
module approx_mult_pipe #(
    parameter int W = 8,
    parameter int L = 4,
    parameter int T = 6
) (
    input  logic              clk,
    input  logic              rst,
    approx_mult_pipe_if.slave bus,
    output logic [31:0]       approx_cnt
);
    localparam int PW = 2 * W;

    function automatic logic [PW-1:0] trunc_mask();
        logic [PW-1:0] m;
        for (int i = 0; i < PW; i++) m[i] = (i >= T);
        return m;
    endfunction

    localparam logic [PW-1:0] TMASK = trunc_mask();

    logic          s1_valid, s1_exact;
    logic [W-1:0]  s1_x, s1_y;
    logic          s2_valid, s2_exact;
    logic [PW-1:0] s2_hi, s2_msum, s2_p;
    logic          s3_valid, s3_exact;
    logic [PW-1:0] s3_z, s3_err;
    logic          adv;
    logic [PW-1:0] y_ext, hi_prod, m_sum, p_full, approx_sum;

    // One global stall: every stage moves together, bubbles included.
    assign adv          = !s3_valid || bus.out_ready;
    assign bus.in_ready = adv;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_exact <= 1'b0;
            s1_x     <= '0;
            s1_y     <= '0;
        end else if (adv) begin
            s1_valid <= bus.in_valid;
            if (bus.in_valid) begin
                s1_x     <= bus.in_x;
                s1_y     <= bus.in_y;
                s1_exact <= bus.in_exact;
            end
        end
    end

    assign y_ext  = PW'(s1_y);
    assign p_full = y_ext * PW'(s1_x);

    generate
        if (L < W) begin : g_high
            assign hi_prod = (y_ext * PW'(s1_x[W-1:L])) << L;
        end else begin : g_no_high
            assign hi_prod = '0;
        end
    endgenerate

    always_comb begin
        logic [PW-1:0] row_a;
        logic [PW-1:0] row_b;
        row_a = '0;
        row_b = '0;
        m_sum = '0;
        for (int k = 0; k < L / 2; k++) begin
            row_a = (y_ext & {PW{s1_x[2*k]}}) << (2 * k);
            row_b = (y_ext & {PW{s1_x[2*k+1]}}) << (2 * k + 1);
            m_sum = m_sum + ((row_a | row_b) & TMASK);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s2_valid <= 1'b0;
            s2_exact <= 1'b0;
            s2_hi    <= '0;
            s2_msum  <= '0;
            s2_p     <= '0;
        end else if (adv) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                s2_exact <= s1_exact;
                s2_hi    <= hi_prod;
                s2_msum  <= m_sum;
                s2_p     <= p_full;
            end
        end
    end

    // The approximate sum never exceeds the exact product, so the error cannot wrap.
    assign approx_sum = s2_hi + s2_msum;

    always_ff @(posedge clk) begin
        if (rst) begin
            s3_valid <= 1'b0;
            s3_exact <= 1'b0;
            s3_z     <= '0;
            s3_err   <= '0;
        end else if (adv) begin
            s3_valid <= s2_valid;
            if (s2_valid) begin
                s3_exact <= s2_exact;
                s3_z     <= s2_exact ? s2_p : approx_sum;
                s3_err   <= s2_exact ? '0 : (s2_p - approx_sum);
            end
        end
    end

    assign bus.out_valid = s3_valid;
    assign bus.out_z     = s3_z;
    assign bus.out_err   = s3_err;

    always_ff @(posedge clk) begin
        if (rst) begin
            approx_cnt <= '0;
        end else if (s3_valid && bus.out_ready && !s3_exact && (approx_cnt != 32'hFFFF_FFFF)) begin
            approx_cnt <= approx_cnt + 32'd1;
        end
    end
endmodule

// File: tb/tb_approx_mult_pipe.sv
// Directed checks of approx_mult_pipe, plus a parameter sweep against a row-by-row reference model.
module tb_approx_mult_pipe;
    localparam int NSW = 12;
    localparam int NV  = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    approx_mult_pipe_if #(.W(8)) mif ();
    logic [31:0] cnt;

    approx_mult_pipe #(.W(8), .L(4), .T(6)) dut (
        .clk(clk), .rst(rst), .bus(mif), .approx_cnt(cnt)
    );

    // Shared stimulus for the sweep instances.
    logic        sw_valid = 1'b0;
    logic [7:0]  sw_x = '0, sw_y = '0;
    logic [15:0] sw_z   [NSW];
    logic [15:0] sw_err [NSW];
    logic        sw_ov  [NSW];
    logic [31:0] sw_cnt [NSW];
    logic [11:0] wx = '0, wy = '0;
    logic [23:0] w_z, w_err;
    logic        w_ov;
    logic [31:0] w_cnt;

    function automatic int sweep_l(int i);
        return 2 * (i / 3 + 1);
    endfunction

    function automatic int sweep_t(int i);
        case (i % 3)
            0:       return 0;
            1:       return 6;
            default: return 16;
        endcase
    endfunction

    generate
        for (genvar gi = 0; gi < NSW; gi++) begin : g_sw
            approx_mult_pipe_if #(.W(8)) sif ();
            assign sif.in_valid  = sw_valid;
            assign sif.in_x      = sw_x;
            assign sif.in_y      = sw_y;
            assign sif.in_exact  = 1'b0;
            assign sif.out_ready = 1'b1;
            assign sw_z[gi]      = sif.out_z;
            assign sw_err[gi]    = sif.out_err;
            assign sw_ov[gi]     = sif.out_valid;
            approx_mult_pipe #(.W(8), .L(sweep_l(gi)), .T(sweep_t(gi))) u_sw (
                .clk(clk), .rst(rst), .bus(sif), .approx_cnt(sw_cnt[gi])
            );
        end
    endgenerate

    approx_mult_pipe_if #(.W(12)) wif ();
    assign wif.in_valid  = sw_valid;
    assign wif.in_x      = wx;
    assign wif.in_y      = wy;
    assign wif.in_exact  = 1'b0;
    assign wif.out_ready = 1'b1;
    assign w_z           = wif.out_z;
    assign w_err         = wif.out_err;
    assign w_ov          = wif.out_valid;

    approx_mult_pipe #(.W(12), .L(6), .T(8)) u_w12 (
        .clk(clk), .rst(rst), .bus(wif), .approx_cnt(w_cnt)
    );

    // Reference: exact high rows summed one by one, low rows paired, ORed and truncated.
    function automatic longint ref_approx(int w, int l, int t, longint x, longint y);
        longint hi, msum, r, ra, rb;
        hi   = 0;
        msum = 0;
        for (int i = l; i < w; i++)
            if (((x >> i) & 1) != 0) hi += (y << i);
        for (int k = 0; k < l / 2; k++) begin
            ra   = (((x >> (2 * k)) & 1) != 0) ? (y << (2 * k)) : 0;
            rb   = (((x >> (2 * k + 1)) & 1) != 0) ? (y << (2 * k + 1)) : 0;
            r    = ((ra | rb) >> t) << t;
            msum += r;
        end
        return hi + msum;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_single(input logic [7:0] x, input logic [7:0] y, input logic ex,
                              output logic [15:0] z, output logic [15:0] err, output int lat);
        mif.in_x      = x;
        mif.in_y      = y;
        mif.in_exact  = ex;
        mif.in_valid  = 1'b1;
        mif.out_ready = 1'b1;
        tick();
        mif.in_valid = 1'b0;
        lat = 1;
        while (!mif.out_valid && lat < 10) begin
            tick();
            lat++;
        end
        z   = mif.out_z;
        err = mif.out_err;
        tick();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        checks++;
        if (mif.out_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_out_valid: got %b expected 0", mif.out_valid); end
        checks++;
        if (mif.out_z !== 16'h0) begin errors++; $display("[TB] FAIL reset_out_z: got %h expected 0000", mif.out_z); end
        checks++;
        if (mif.out_err !== 16'h0) begin errors++; $display("[TB] FAIL reset_out_err: got %h expected 0000", mif.out_err); end
        checks++;
        if (cnt !== 32'h0) begin errors++; $display("[TB] FAIL reset_cnt: got %0d expected 0", cnt); end
        checks++;
        if (mif.in_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_in_ready: got %b expected 1", mif.in_ready); end
    endtask

    task automatic test_approx_basic();
        logic [15:0] z, err;
        int lat;
        run_single(8'h0F, 8'hFF, 1'b0, z, err, lat);
        checks++;
        if (lat !== 3) begin errors++; $display("[TB] FAIL basic_latency: got %0d expected 3", lat); end
        checks++;
        if (z !== 16'h0980) begin errors++; $display("[TB] FAIL basic_z: got %h expected 0980", z); end
        checks++;
        if (err !== 16'h0571) begin errors++; $display("[TB] FAIL basic_err: got %h expected 0571", err); end
        checks++;
        if (cnt !== 32'd1) begin errors++; $display("[TB] FAIL basic_cnt: got %0d expected 1", cnt); end
    endtask

    task automatic test_exact_mode();
        logic [15:0] z, err;
        int lat;
        run_single(8'hFF, 8'hFF, 1'b0, z, err, lat);
        checks++;
        if (z !== 16'hF890) begin errors++; $display("[TB] FAIL ff_approx_z: got %h expected f890", z); end
        checks++;
        if (err !== 16'h0571) begin errors++; $display("[TB] FAIL ff_approx_err: got %h expected 0571", err); end
        checks++;
        if (cnt !== 32'd2) begin errors++; $display("[TB] FAIL ff_approx_cnt: got %0d expected 2", cnt); end
        run_single(8'hFF, 8'hFF, 1'b1, z, err, lat);
        checks++;
        if (z !== 16'hFE01) begin errors++; $display("[TB] FAIL ff_exact_z: got %h expected fe01", z); end
        checks++;
        if (err !== 16'h0000) begin errors++; $display("[TB] FAIL ff_exact_err: got %h expected 0000", err); end
        checks++;
        if (cnt !== 32'd2) begin errors++; $display("[TB] FAIL ff_exact_cnt: got %0d expected 2", cnt); end
    endtask

    task automatic test_zero_low_rows();
        logic [15:0] z, err;
        int lat;
        run_single(8'h10, 8'h03, 1'b0, z, err, lat);
        checks++;
        if (z !== 16'h0030) begin errors++; $display("[TB] FAIL zero_low_z: got %h expected 0030", z); end
        checks++;
        if (err !== 16'h0000) begin errors++; $display("[TB] FAIL zero_low_err: got %h expected 0000", err); end
    endtask

    task automatic test_back_to_back();
        logic [7:0]  bx [8] = '{8'h0F, 8'hFF, 8'h10, 8'hA5, 8'h3C, 8'h81, 8'h7E, 8'hFF};
        logic [7:0]  by [8] = '{8'hFF, 8'hFF, 8'h03, 8'h5A, 8'hC3, 8'h99, 8'hE7, 8'h01};
        logic        be [8] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        logic [15:0] ez [8];
        logic [15:0] ee [8];
        logic [31:0] cnt0;
        int          n_approx;
        longint      p, a;
        n_approx = 0;
        for (int i = 0; i < 8; i++) begin
            p = longint'(bx[i]) * longint'(by[i]);
            a = ref_approx(8, 4, 6, longint'(bx[i]), longint'(by[i]));
            ez[i] = be[i] ? 16'(p) : 16'(a);
            ee[i] = be[i] ? 16'h0 : 16'(p - a);
            if (!be[i]) n_approx++;
        end
        cnt0 = cnt;
        mif.out_ready = 1'b1;
        fork
            begin
                int  i, guard;
                logic acc;
                i = 0;
                guard = 0;
                while (i < 8 && guard < 100) begin
                    mif.in_valid = 1'b1;
                    mif.in_x     = bx[i];
                    mif.in_y     = by[i];
                    mif.in_exact = be[i];
                    @(negedge clk);
                    acc = mif.in_ready;
                    tick();
                    if (acc) i++;
                    guard++;
                end
                mif.in_valid = 1'b0;
            end
            begin
                repeat (4) tick();
                mif.out_ready = 1'b0;
                repeat (5) tick();
                mif.out_ready = 1'b1;
            end
            begin
                int          got, cyc;
                logic        held;
                logic [15:0] prev_z, prev_e;
                got  = 0;
                cyc  = 0;
                held = 1'b0;
                while (got < 8 && cyc < 100) begin
                    @(negedge clk);
                    cyc++;
                    if (mif.out_valid && !mif.out_ready) begin
                        checks++;
                        if (mif.in_ready !== 1'b0) begin errors++; $display("[TB] FAIL b2b_in_ready_stall: got %b expected 0", mif.in_ready); end
                        if (held) begin
                            checks++;
                            if (mif.out_z !== prev_z || mif.out_err !== prev_e) begin
                                errors++;
                                $display("[TB] FAIL b2b_hold: got %h/%h expected %h/%h", mif.out_z, mif.out_err, prev_z, prev_e);
                            end
                        end
                        prev_z = mif.out_z;
                        prev_e = mif.out_err;
                        held   = 1'b1;
                    end else if (mif.out_valid && mif.out_ready) begin
                        checks++;
                        if (mif.out_z !== ez[got] || mif.out_err !== ee[got]) begin
                            errors++;
                            $display("[TB] FAIL b2b_result%0d: got %h/%h expected %h/%h", got, mif.out_z, mif.out_err, ez[got], ee[got]);
                        end
                        got++;
                        held = 1'b0;
                    end
                end
                checks++;
                if (got != 8) begin errors++; $display("[TB] FAIL b2b_timeout: got %0d results expected 8", got); end
            end
        join
        tick();
        checks++;
        if (mif.out_valid !== 1'b0) begin errors++; $display("[TB] FAIL b2b_extra_result: got out_valid %b expected 0", mif.out_valid); end
        checks++;
        if (cnt !== cnt0 + 32'(n_approx)) begin errors++; $display("[TB] FAIL b2b_cnt: got %0d expected %0d", cnt, cnt0 + 32'(n_approx)); end
    endtask

    task automatic test_reset_midflight();
        logic [15:0] z, err;
        int          lat;
        logic        seen;
        mif.out_ready = 1'b0;
        mif.in_exact  = 1'b0;
        for (int i = 0; i < 3; i++) begin
            mif.in_valid = 1'b1;
            mif.in_x     = 8'(8'h31 + i);
            mif.in_y     = 8'hC7;
            tick();
        end
        mif.in_valid = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        mif.out_ready = 1'b1;
        checks++;
        if (mif.out_valid !== 1'b0) begin errors++; $display("[TB] FAIL midrst_out_valid: got %b expected 0", mif.out_valid); end
        checks++;
        if (cnt !== 32'd0) begin errors++; $display("[TB] FAIL midrst_cnt: got %0d expected 0", cnt); end
        seen = 1'b0;
        repeat (6) begin
            tick();
            if (mif.out_valid) seen = 1'b1;
        end
        checks++;
        if (seen !== 1'b0) begin errors++; $display("[TB] FAIL midrst_stale: got stale result %b expected 0", seen); end
        run_single(8'h0F, 8'hFF, 1'b0, z, err, lat);
        checks++;
        if (lat !== 3 || z !== 16'h0980 || err !== 16'h0571) begin
            errors++;
            $display("[TB] FAIL midrst_next_beat: got lat %0d z %h err %h expected lat 3 z 0980 err 0571", lat, z, err);
        end
    endtask

    task automatic test_sweep();
        longint xv, yv, a, p;
        for (int v = 0; v < NV; v++) begin
            case (v)
                0:       begin sw_x = 8'hFF; sw_y = 8'hFF; wx = 12'hFFF; wy = 12'hFFF; end
                1:       begin sw_x = 8'h00; sw_y = 8'hFF; wx = 12'h000; wy = 12'hABC; end
                2:       begin sw_x = 8'hAA; sw_y = 8'h55; wx = 12'h0AA; wy = 12'h800; end
                default: begin sw_x = 8'($urandom); sw_y = 8'($urandom); wx = 12'($urandom); wy = 12'($urandom); end
            endcase
            sw_valid = 1'b1;
            tick();
            sw_valid = 1'b0;
            tick();
            tick();
            xv = longint'(sw_x);
            yv = longint'(sw_y);
            p  = xv * yv;
            for (int i = 0; i < NSW; i++) begin
                a = ref_approx(8, sweep_l(i), sweep_t(i), xv, yv);
                checks++;
                if (sw_ov[i] !== 1'b1 || longint'(sw_z[i]) != a || longint'(sw_z[i]) + longint'(sw_err[i]) != p) begin
                    errors++;
                    $display("[TB] FAIL sweep_L%0d_T%0d: x %h y %h got v %b z %h err %h expected z %h err %h",
                             sweep_l(i), sweep_t(i), sw_x, sw_y, sw_ov[i], sw_z[i], sw_err[i], 16'(a), 16'(p - a));
                end
            end
            xv = longint'(wx);
            yv = longint'(wy);
            p  = xv * yv;
            a  = ref_approx(12, 6, 8, xv, yv);
            checks++;
            if (w_ov !== 1'b1 || longint'(w_z) != a || longint'(w_z) + longint'(w_err) != p) begin
                errors++;
                $display("[TB] FAIL sweep_W12: x %h y %h got v %b z %h err %h expected z %h err %h",
                         wx, wy, w_ov, w_z, w_err, 24'(a), 24'(p - a));
            end
            tick();
        end
        for (int i = 0; i < NSW; i++) begin
            checks++;
            if (sw_cnt[i] !== 32'(NV)) begin errors++; $display("[TB] FAIL sweep_cnt%0d: got %0d expected %0d", i, sw_cnt[i], NV); end
        end
        checks++;
        if (w_cnt !== 32'(NV)) begin errors++; $display("[TB] FAIL sweep_cnt_w12: got %0d expected %0d", w_cnt, NV); end
    endtask

    initial begin
        mif.in_valid  = 1'b0;
        mif.in_x      = '0;
        mif.in_y      = '0;
        mif.in_exact  = 1'b0;
        mif.out_ready = 1'b1;
        test_reset();
        test_approx_basic();
        test_exact_mode();
        test_zero_low_rows();
        test_back_to_back();
        test_reset_midflight();
        test_sweep();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
